trigger_qualify: RTL and testbench
==================================

// Module: trigger_qualify
//
// PURPOSE
//   Input-side counterpart of the trigger hold latch. The latch stretches a short trigger into a
//   long hold; this block takes a slow, noisy external level and produces the clean trigger.
//   - Synchronises an asynchronous input into clk.
//   - Requires the input to hold a new value for STABLE consecutive cycles before accepting it.
//   - Outputs: the qualified level, one-cycle rise/fall strobes and a wrapping count of accepted rises.
//   - Sits between a front-panel or external pin and any trigger consumer, for example the hold latch.
//
// PARAMETERS
//   STABLE  20000000/1000  consecutive in_s samples needed to accept a change (>=1); 1 ms at 20 MHz
//   CNT_W   32             stability counter width; must satisfy 2**CNT_W > STABLE
//   EVT_W   16             width of the accepted-rise event counter
//
// PORTS
//   clk      in   1      system clock; all logic on posedge
//   rst_n    in   1      asynchronous reset, active low
//   sig_i    in   1      raw asynchronous input level, active high
//   en_i     in   1      1 = qualify; 0 = freeze level_o, clear stability counter, no strobes
//   clr_i    in   1      synchronous clear of evt_o
//   level_o  out  1      qualified level (registered)
//   rise_o   out  1      one-cycle strobe on accepted 0->1 (registered)
//   fall_o   out  1      one-cycle strobe on accepted 1->0 (registered)
//   evt_o    out  EVT_W  count of accepted rises, wraps modulo 2**EVT_W
//
// BEHAVIOUR
//   Reset (rst_n=0, asynchronous):
//     - sync[1:0]=0, cnt=0, state=LOW.
//     - level_o=0, rise_o=0, fall_o=0, evt_o=0.
//     - A reset mid-qualification discards the partial count.
//   Synchroniser:
//     - Two-flop chain, sync[0]<=sig_i, sync[1]<=sync[0]; in_s = sync[1].
//     - in_s is never bypassed; sig_i reaches no other logic.
//   FSM, 4 states:
//     - LOW: if in_s=1 and STABLE=1 -> HIGH. Else if in_s=1 -> QUAL_HI with cnt<=1.
//     - QUAL_HI:
//         - in_s=0 -> LOW, cnt<=0 (glitch rejected, no strobe).
//         - in_s=1 and cnt=STABLE-1 -> HIGH, cnt<=0.
//         - otherwise cnt<=cnt+1.
//     - HIGH, QUAL_LO: mirror images of LOW, QUAL_HI with in_s inverted.
//     - A single opposite sample returns to the stable state and restarts qualification from 0.
//   Outputs:
//     - level_o=1 exactly in HIGH and QUAL_LO.
//     - On the edge that enters HIGH: rise_o<=1, evt_o<=evt_o+1. On the edge that enters LOW from QUAL_LO: fall_o<=1.
//     - Strobes are 0 on every other cycle; never two consecutive cycles.
//   Latency:
//     - sig_i change first sampled at edge N, held stable: level_o and strobe update at edge N+1+STABLE.
//     - That is 2 synchroniser edges plus STABLE qualifying samples, overlapping by one.
//   Enable:
//     - en_i=0: state returns to the stable state matching level_o, cnt<=0, strobes 0.
//     - level_o and evt_o hold. The synchroniser keeps running.
//     - Re-enable restarts qualification from 0.
//   Event counter:
//     - clr_i=1 forces evt_o<=0.
//     - If clr_i coincides with an accepted rise, clear wins: evt_o=0, rise_o still 1.
//     - At 2**EVT_W-1, a rise wraps evt_o to 0.
//   Counter width: cnt never exceeds STABLE-1, so no overflow path exists.
//
// TESTING  (STABLE=4 unless stated)
//   - Reset, sig_i 0->1 sampled at edge N, held -> level_o=1 and rise_o=1 at edge N+5 only; evt_o=1.
//   - sig_i high for 3 cycles then low -> no rise_o, level_o stays 0, evt_o stays 0.
//   - From HIGH, sig_i low 3 cycles, high 1 cycle, low 4 cycles -> exactly one fall_o, at the edge 5 after the second low period is first sampled.
//   - en_i=0 during QUAL_HI, then en_i=1 with sig_i held high -> rise_o arrives 4 samples after re-enable, not earlier.
//   - EVT_W=2, 5 qualified pulses -> evt_o reads 1,2,3,0,1. clr_i on the 5th rise edge -> evt_o=0.
//   - rst_n low mid-QUAL_HI (async, between edges) -> outputs 0 immediately; input still high -> full STABLE re-qualification, then rise_o.

Source files
------------

// File: rtl/trigger_qualify.sv
// Trigger input qualifier: synchronises a slow external level, requires STABLE consecutive
// equal samples before accepting a change, and reports level, edge strobes and a rise count.
module trigger_qualify #(
  parameter int unsigned STABLE = 20000000 / 1000,
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned EVT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_i,
  input  logic             en_i,
  input  logic             clr_i,
  output logic             level_o,
  output logic             rise_o,
  output logic             fall_o,
  output logic [EVT_W-1:0] evt_o
);

  typedef enum logic [1:0] {
    LOW     = 2'd0,
    QUAL_HI = 2'd1,
    HIGH    = 2'd2,
    QUAL_LO = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE - 1);
  localparam bit               ONE_SHOT = (STABLE == 1);

  logic [1:0]       sync_q;
  logic             in_s;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rise_d, fall_d, level_d;

  assign in_s = sync_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[0], sig_i};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (!en_i) begin
      // Fall back to whichever stable state matches the level already presented.
      state_d = level_o ? HIGH : LOW;
      cnt_d   = '0;
    end else begin
      case (state_q)
        LOW: begin
          if (in_s) begin
            if (ONE_SHOT) begin
              state_d = HIGH;
              rise_d  = 1'b1;
            end else begin
              state_d = QUAL_HI;
              cnt_d   = CNT_W'(1);
            end
          end
        end
        QUAL_HI: begin
          if (!in_s) begin
            state_d = LOW;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = HIGH;
            cnt_d   = '0;
            rise_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        HIGH: begin
          if (!in_s) begin
            if (ONE_SHOT) begin
              state_d = LOW;
              fall_d  = 1'b1;
            end else begin
              state_d = QUAL_LO;
              cnt_d   = CNT_W'(1);
            end
          end
        end
        QUAL_LO: begin
          if (in_s) begin
            state_d = HIGH;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = LOW;
            cnt_d   = '0;
            fall_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = LOW;
          cnt_d   = '0;
        end
      endcase
    end
    level_d = (state_d == HIGH) || (state_d == QUAL_LO);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOW;
      cnt_q   <= '0;
      level_o <= 1'b0;
      rise_o  <= 1'b0;
      fall_o  <= 1'b0;
      evt_o   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_o <= level_d;
      rise_o  <= rise_d;
      fall_o  <= fall_d;
      if (clr_i)       evt_o <= '0;
      else if (rise_d) evt_o <= evt_o + EVT_W'(1);
    end
  end

endmodule

// File: tb/tb_trigger_qualify.sv
// Self-checking bench for trigger_qualify with STABLE=4, EVT_W=2; expected outputs are
// queued per clock edge from the stimulus timeline and popped once the edge has occurred.
module tb_trigger_qualify;

  localparam int unsigned EW = 2;

  logic          clk;
  logic          rst_n;
  logic          sig_i;
  logic          en_i;
  logic          clr_i;
  logic          level_o;
  logic          rise_o;
  logic          fall_o;
  logic [EW-1:0] evt_o;

  int unsigned total = 0;
  int unsigned bad   = 0;

  // {level, rise, fall, evt}
  logic [EW+2:0] exp_q[$];
  logic [EW+2:0] exp_v;
  logic [EW+2:0] got_v;
  logic [EW-1:0] exp_evt;

  trigger_qualify #(
    .STABLE(4),
    .CNT_W (8),
    .EVT_W (EW)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .sig_i  (sig_i),
    .en_i   (en_i),
    .clr_i  (clr_i),
    .level_o(level_o),
    .rise_o (rise_o),
    .fall_o (fall_o),
    .evt_o  (evt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1);
  end

  task automatic test_reset();
    rst_n = 1'b0; sig_i = 1'b0; en_i = 1'b1; clr_i = 1'b0;
    #1;
    got_v = {level_o, rise_o, fall_o, evt_o};
    total++;
    if (got_v !== '0) begin
      bad++;
      $display("FAIL reset_async: got %b want %b", got_v, {(EW+3){1'b0}});
    end
    @(posedge clk); @(posedge clk); #1;
    got_v = {level_o, rise_o, fall_o, evt_o};
    total++;
    if (got_v !== '0) begin
      bad++;
      $display("FAIL reset_held: got %b want %b", got_v, {(EW+3){1'b0}});
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back('0);
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      got_v = {level_o, rise_o, fall_o, evt_o};
      total++;
      if (got_v !== exp_v) begin
        bad++;
        $display("FAIL reset_idle step %0d: got %b want %b", i, got_v, exp_v);
      end
    end
    exp_evt = '0;
  endtask

  // Three high samples (STABLE-1) must be rejected.
  task automatic test_glitch();
    for (int i = 0; i < 11; i++) begin
      sig_i = (i < 3);
      exp_q.push_back({1'b0, 1'b0, 1'b0, exp_evt});
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      got_v = {level_o, rise_o, fall_o, evt_o};
      total++;
      if (got_v !== exp_v) begin
        bad++;
        $display("FAIL glitch step %0d: got %b want %b", i, got_v, exp_v);
      end
    end
  endtask

  // sig_i first sampled at step 0 -> accepted at step 5.
  task automatic test_rise();
    for (int i = 0; i < 8; i++) begin
      sig_i = 1'b1;
      if (i == 5) exp_evt = exp_evt + 1'b1;
      exp_q.push_back({i >= 5, i == 5, 1'b0, exp_evt});
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      got_v = {level_o, rise_o, fall_o, evt_o};
      total++;
      if (got_v !== exp_v) begin
        bad++;
        $display("FAIL rise step %0d: got %b want %b", i, got_v, exp_v);
      end
    end
  endtask

  // Low 3, high 1, low: second low first sampled at step 4, fall at step 9.
  task automatic test_fall_restart();
    for (int i = 0; i < 12; i++) begin
      sig_i = (i == 3);
      exp_q.push_back({i < 9, 1'b0, i == 9, exp_evt});
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      got_v = {level_o, rise_o, fall_o, evt_o};
      total++;
      if (got_v !== exp_v) begin
        bad++;
        $display("FAIL fall_restart step %0d: got %b want %b", i, got_v, exp_v);
      end
    end
  endtask

  // Enable dropped for steps 3..5 mid-qualification; re-enabled at 6 -> rise at 9.
  task automatic test_enable();
    for (int i = 0; i < 12; i++) begin
      sig_i = 1'b1;
      en_i  = !(i >= 3 && i <= 5);
      if (i == 9) exp_evt = exp_evt + 1'b1;
      exp_q.push_back({i >= 9, i == 9, 1'b0, exp_evt});
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      got_v = {level_o, rise_o, fall_o, evt_o};
      total++;
      if (got_v !== exp_v) begin
        bad++;
        $display("FAIL enable step %0d: got %b want %b", i, got_v, exp_v);
      end
    end
    en_i = 1'b1;
  endtask

  // Clear, then six pulses: evt 1,2,3,0,1 and a clear coinciding with the sixth rise.
  task automatic test_evt_wrap();
    for (int ph = 0; ph < 13; ph++) begin
      for (int s = 0; s < 8; s++) begin
        logic hi_ph;
        logic clr_now;
        hi_ph   = ph[0];
        clr_now = (ph == 0 && s == 0) || (ph == 11 && s == 5);
        sig_i   = hi_ph;
        clr_i   = clr_now;
        if (clr_now) exp_evt = '0;
        else if (hi_ph && s == 5) exp_evt = exp_evt + 1'b1;
        if (hi_ph) exp_q.push_back({s >= 5, s == 5, 1'b0, exp_evt});
        else       exp_q.push_back({s < 5, 1'b0, s == 5, exp_evt});
        @(posedge clk); #1;
        exp_v = exp_q.pop_front();
        got_v = {level_o, rise_o, fall_o, evt_o};
        total++;
        if (got_v !== exp_v) begin
          bad++;
          $display("FAIL evt_wrap phase %0d step %0d: got %b want %b", ph, s, got_v, exp_v);
        end
      end
    end
    clr_i = 1'b0;
  endtask

  // Reset pulse between edges while in QUAL_HI, input stays high.
  task automatic test_async_reset();
    for (int i = 0; i < 4; i++) begin
      sig_i = 1'b1;
      exp_q.push_back({1'b0, 1'b0, 1'b0, exp_evt});
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      got_v = {level_o, rise_o, fall_o, evt_o};
      total++;
      if (got_v !== exp_v) begin
        bad++;
        $display("FAIL areset_pre step %0d: got %b want %b", i, got_v, exp_v);
      end
    end
    #2 rst_n = 1'b0;
    #1;
    got_v = {level_o, rise_o, fall_o, evt_o};
    total++;
    if (got_v !== '0) begin
      bad++;
      $display("FAIL areset_immediate: got %b want %b", got_v, {(EW+3){1'b0}});
    end
    #2 rst_n = 1'b1;
    exp_evt = '0;
    for (int j = 0; j < 8; j++) begin
      if (j == 5) exp_evt = exp_evt + 1'b1;
      exp_q.push_back({j >= 5, j == 5, 1'b0, exp_evt});
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      got_v = {level_o, rise_o, fall_o, evt_o};
      total++;
      if (got_v !== exp_v) begin
        bad++;
        $display("FAIL areset_requal step %0d: got %b want %b", j, got_v, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_rise();
    test_fall_restart();
    test_enable();
    test_evt_wrap();
    test_async_reset();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
